// File: rtl/demo_counter8.sv
// Enabled up-counter with programmable terminal value,
// combinational terminal count and saturating wrap counter.
module demo_counter8 #(
  parameter int WIDTH = 8,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  output logic [WIDTH-1:0] Count,
  output logic             Tc,
  output logic [WIDTH-1:0] Wraps
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic at_max;
  logic wraps_full;

  assign at_max     = (Count == MAX_W);
  assign wraps_full = (Wraps == {WIDTH{1'b1}});
  assign Tc         = En & at_max;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Count <= '0;
    end else if (En) begin
      if (at_max) Count <= '0;
      else        Count <= Count + 1'b1;
    end
  end

  // Wrap counter sticks at all-ones instead of rolling over
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Wraps <= '0;
    end else if (Tc && !wraps_full) begin
      Wraps <= Wraps + 1'b1;
    end
  end

endmodule

// File: tb/tb_demo_counter8.sv
// Directed bench for demo_counter8: default, MAX_VAL=9 and
// MAX_VAL=1 (wrap saturation) instances share clock, reset, enable.
`timescale 1ns/1ps
module tb_demo_counter8;

  logic       Clk;
  logic       Rst;
  logic       En;
  logic [7:0] count;
  logic       tc;
  logic [7:0] wraps;
  logic [7:0] count9;
  logic       tc9;
  logic [7:0] wraps9;
  logic [7:0] count1;
  logic       tc1;
  logic [7:0] wraps1;

  int errs;
  int checks;

  demo_counter8 #(.WIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .En(En),
    .Count(count), .Tc(tc), .Wraps(wraps)
  );

  demo_counter8 #(.WIDTH(8), .MAX_VAL(9)) dut9 (
    .Clk(Clk), .Rst(Rst), .En(En),
    .Count(count9), .Tc(tc9), .Wraps(wraps9)
  );

  demo_counter8 #(.WIDTH(8), .MAX_VAL(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .En(En),
    .Count(count1), .Tc(tc1), .Wraps(wraps1)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  int seq9 [25] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0,
                    1, 2, 3, 4, 5, 6, 7, 8, 9, 0,
                    1, 2, 3, 4, 5};

  initial begin
    errs   = 0;
    checks = 0;
    Rst    = 1'b1;
    En     = 1'b0;

    // power-up: reset held for 100 ns, then idle 100 ns
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("rst_count", count, 0);
      chk("rst_wraps", wraps, 0);
      chk("rst_tc", tc, 0);
    end
    Rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("idle_count", count, 0);
      chk("idle_wraps", wraps, 0);
      chk("idle_tc", tc, 0);
    end

    // count run: 100 edges, one step each
    En = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      chk("run_count", count, i);
    end
    chk("run_100", count, 100);
    chk("run_tc", tc, 0);

    // continue to 255, then wrap on edge 256
    tick(155);
    chk("top_count", count, 255);
    chk("top_tc", tc, 1);
    chk("top_wraps", wraps, 0);
    tick(1);
    chk("wrap_count", count, 0);
    chk("wrap_wraps", wraps, 1);
    chk("wrap_tc", tc, 0);

    // hold at 37 for 10 edges
    tick(37);
    chk("pre_hold", count, 37);
    En = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("hold_count", count, 37);
      chk("hold_tc", tc, 0);
    end
    En = 1'b1;
    tick(1);
    chk("resume_count", count, 38);

    // async reset pulse between edges at 200
    tick(162);
    chk("pre_arst", count, 200);
    #2 Rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_wraps", wraps, 0);
    chk("arst_tc", tc, 0);
    #4 Rst = 1'b0;
    tick(1);
    chk("arst_resume", count, 1);

    // reset wins over enable at an edge
    Rst = 1'b1;
    tick(2);
    chk("prio_count", count, 0);
    chk("prio_wraps", wraps, 0);

    // MAX_VAL=9 sequence, and MAX_VAL=1 saturation run
    Rst = 1'b0;
    chk("p9_start", count9, 0);
    for (int i = 0; i < 25; i++) begin
      tick(1);
      chk("p9_count", count9, seq9[i]);
      chk("p9_tc", tc9, (seq9[i] == 9) ? 1 : 0);
    end
    chk("p9_wraps", wraps9, 2);
    chk("p1_wraps_mid", wraps1, 12);
    chk("p1_count_mid", count1, 1);
    chk("p1_tc_mid", tc1, 1);

    tick(485);
    chk("p1_wraps_510", wraps1, 255);
    chk("p1_count_510", count1, 0);
    tick(20);
    chk("p1_wraps_sat", wraps1, 255);
    chk("p1_count_530", count1, 0);
    tick(1);
    chk("p1_count_531", count1, 1);
    tick(1);
    chk("p1_wraps_hold", wraps1, 255);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
